// File: rtl/tcb_lite_sub_memory.sv
// TCB-lite subordinate memory: single-port word array with a fixed-latency response pipeline.
// Supports byte-enable (MODE=1) and logarithmic-size (MODE=0) request encodings.
module tcb_lite_sub_memory #(
    parameter int DELAY = 1,
    parameter int WIDTH = 32,
    parameter int MODE  = 1,
    parameter int DEPTH = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tcb_req_vld,
    output logic               tcb_req_rdy,
    input  logic               tcb_req_wen,
    input  logic [WIDTH-1:0]   tcb_req_adr,
    input  logic [1:0]         tcb_req_siz,
    input  logic [WIDTH/8-1:0] tcb_req_byt,
    input  logic [WIDTH-1:0]   tcb_req_wdt,
    output logic               tcb_rsp_vld,
    output logic [WIDTH-1:0]   tcb_rsp_rdt,
    output logic               tcb_rsp_err
);

    localparam int BW = WIDTH / 8;
    localparam int AW = $clog2(BW);
    localparam int IW = $clog2(DEPTH);

    logic             rdy_q, rdy_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             vld_q [DELAY];
    logic             vld_d [DELAY];
    logic [WIDTH-1:0] rdt_q [DELAY];
    logic [WIDTH-1:0] rdt_d [DELAY];
    logic             err_q [DELAY];
    logic             err_d [DELAY];

    logic             xfer;
    logic [IW-1:0]    idx;
    logic [AW-1:0]    lane;
    logic [AW-1:0]    align_mask;
    logic [3:0]       nbytes;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] rd_shift;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] wr_data;
    logic [BW-1:0]    byt_en;
    logic             req_err;
    logic             unused_bits;

    assign xfer        = tcb_req_vld & rdy_q;
    assign idx         = tcb_req_adr[AW +: IW];
    assign lane        = tcb_req_adr[AW-1:0];
    assign nbytes      = 4'd1 << tcb_req_siz;
    assign align_mask  = AW'(nbytes - 4'd1);
    assign word        = mem_q[idx];
    assign rd_shift    = word >> (8 * int'(lane));
    // Address bits above the word index only wrap; they carry no meaning here.
    assign unused_bits = ^tcb_req_adr;

    always_comb begin
        req_err = 1'b0;
        byt_en  = tcb_req_byt;
        wr_data = tcb_req_wdt;
        rd_data = word;
        if (MODE == 0) begin
            req_err = (int'(tcb_req_siz) > AW) || ((lane & align_mask) != '0);
            wr_data = tcb_req_wdt << (8 * int'(lane));
            for (int i = 0; i < BW; i++) begin
                byt_en[i] = (i >= int'(lane)) && (i < int'(lane) + int'(nbytes));
                rd_data[8*i +: 8] = (i < int'(nbytes)) ? rd_shift[8*i +: 8] : 8'h00;
            end
        end
    end

    always_comb begin
        rdy_d    = 1'b1;
        vld_d[0] = xfer;
        rdt_d[0] = rdt_q[0];
        err_d[0] = err_q[0];
        if (xfer) begin
            rdt_d[0] = (tcb_req_wen || req_err) ? '0 : rd_data;
            err_d[0] = req_err;
        end
        // Data stages only advance with a valid token so idle cycles hold the last response.
        for (int s = 1; s < DELAY; s++) begin
            vld_d[s] = vld_q[s-1];
            rdt_d[s] = vld_q[s-1] ? rdt_q[s-1] : rdt_q[s];
            err_d[s] = vld_q[s-1] ? err_q[s-1] : err_q[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
            for (int s = 0; s < DELAY; s++) begin
                vld_q[s] <= 1'b0;
                rdt_q[s] <= '0;
                err_q[s] <= 1'b0;
            end
        end else begin
            rdy_q <= rdy_d;
            for (int s = 0; s < DELAY; s++) begin
                vld_q[s] <= vld_d[s];
                rdt_q[s] <= rdt_d[s];
                err_q[s] <= err_d[s];
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (xfer && tcb_req_wen && !req_err) begin
            for (int i = 0; i < BW; i++) begin
                if (byt_en[i]) begin
                    mem_q[idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign tcb_req_rdy = rdy_q;
    assign tcb_rsp_vld = vld_q[DELAY-1];
    assign tcb_rsp_rdt = rdt_q[DELAY-1];
    assign tcb_rsp_err = err_q[DELAY-1];

endmodule

// File: tb/tb_tcb_lite_sub_memory.sv
// Directed bench for tcb_lite_sub_memory: three instances cover byte-enable/DELAY=1,
// log-size/DELAY=3 and reset-discard/DELAY=2 behaviour on a shared request bus.
module tb_tcb_lite_sub_memory;

    logic        clk;
    logic        rst_a, rst_b, rst_c;
    logic        vld_a, vld_b, vld_c;
    logic        wen;
    logic [31:0] adr;
    logic [1:0]  siz;
    logic [3:0]  byt;
    logic [31:0] wdt;

    logic        rdy_a, rdy_b, rdy_c;
    logic        rsp_vld_a, rsp_vld_b, rsp_vld_c;
    logic [31:0] rsp_rdt_a, rsp_rdt_b, rsp_rdt_c;
    logic        rsp_err_a, rsp_err_b, rsp_err_c;

    int checks = 0;
    int errors = 0;

    tcb_lite_sub_memory #(.DELAY(1), .WIDTH(32), .MODE(1), .DEPTH(1024)) u_a (
        .clk(clk), .rst_n(rst_a), .tcb_req_vld(vld_a), .tcb_req_rdy(rdy_a),
        .tcb_req_wen(wen), .tcb_req_adr(adr), .tcb_req_siz(siz), .tcb_req_byt(byt),
        .tcb_req_wdt(wdt), .tcb_rsp_vld(rsp_vld_a), .tcb_rsp_rdt(rsp_rdt_a),
        .tcb_rsp_err(rsp_err_a)
    );

    tcb_lite_sub_memory #(.DELAY(3), .WIDTH(32), .MODE(0), .DEPTH(1024)) u_b (
        .clk(clk), .rst_n(rst_b), .tcb_req_vld(vld_b), .tcb_req_rdy(rdy_b),
        .tcb_req_wen(wen), .tcb_req_adr(adr), .tcb_req_siz(siz), .tcb_req_byt(byt),
        .tcb_req_wdt(wdt), .tcb_rsp_vld(rsp_vld_b), .tcb_rsp_rdt(rsp_rdt_b),
        .tcb_rsp_err(rsp_err_b)
    );

    tcb_lite_sub_memory #(.DELAY(2), .WIDTH(32), .MODE(1), .DEPTH(1024)) u_c (
        .clk(clk), .rst_n(rst_c), .tcb_req_vld(vld_c), .tcb_req_rdy(rdy_c),
        .tcb_req_wen(wen), .tcb_req_adr(adr), .tcb_req_siz(siz), .tcb_req_byt(byt),
        .tcb_req_wdt(wdt), .tcb_rsp_vld(rsp_vld_c), .tcb_rsp_rdt(rsp_rdt_c),
        .tcb_rsp_err(rsp_err_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [1:0] s,
                         input logic [3:0] b, input logic [31:0] d);
        wen = w;
        adr = a;
        siz = s;
        byt = b;
        wdt = d;
    endtask

    // Log-size instance program: op, expected rdt, expected err.
    logic        b_wen [9];
    logic [1:0]  b_siz [9];
    logic [31:0] b_adr [9];
    logic [31:0] b_wdt [9];
    logic [31:0] b_rdt [9];
    logic        b_err [9];

    initial begin
        b_wen[0] = 1; b_siz[0] = 2; b_adr[0] = 32'h20; b_wdt[0] = 32'h0;    b_rdt[0] = 32'h0;        b_err[0] = 0;
        b_wen[1] = 1; b_siz[1] = 1; b_adr[1] = 32'h22; b_wdt[1] = 32'h1234; b_rdt[1] = 32'h0;        b_err[1] = 0;
        b_wen[2] = 1; b_siz[2] = 1; b_adr[2] = 32'h21; b_wdt[2] = 32'hFFFF; b_rdt[2] = 32'h0;        b_err[2] = 1;
        b_wen[3] = 0; b_siz[3] = 0; b_adr[3] = 32'h23; b_wdt[3] = 32'h0;    b_rdt[3] = 32'h12;       b_err[3] = 0;
        b_wen[4] = 0; b_siz[4] = 2; b_adr[4] = 32'h22; b_wdt[4] = 32'h0;    b_rdt[4] = 32'h0;        b_err[4] = 1;
        b_wen[5] = 0; b_siz[5] = 2; b_adr[5] = 32'h20; b_wdt[5] = 32'h0;    b_rdt[5] = 32'h12340000; b_err[5] = 0;
        b_wen[6] = 0; b_siz[6] = 3; b_adr[6] = 32'h20; b_wdt[6] = 32'h0;    b_rdt[6] = 32'h0;        b_err[6] = 1;
        b_wen[7] = 0; b_siz[7] = 1; b_adr[7] = 32'h22; b_wdt[7] = 32'h0;    b_rdt[7] = 32'h1234;     b_err[7] = 0;
        b_wen[8] = 0; b_siz[8] = 0; b_adr[8] = 32'h21; b_wdt[8] = 32'h0;    b_rdt[8] = 32'h0;        b_err[8] = 0;

        rst_a = 0; rst_b = 0; rst_c = 0;
        vld_a = 0; vld_b = 0; vld_c = 0;
        drive(0, 32'h0, 2'd0, 4'h0, 32'h0);

        // Reset state and release.
        tick();
        tick();
        chk("rst_rdy", {31'b0, rdy_a}, 32'd0);
        chk("rst_vld", {31'b0, rsp_vld_a}, 32'd0);
        chk("rst_rdt", rsp_rdt_a, 32'h0);
        rst_a = 1; rst_b = 1; rst_c = 1;
        chk("rel_rdy_first", {31'b0, rdy_a}, 32'd0);
        tick();
        chk("rel_rdy_a", {31'b0, rdy_a}, 32'd1);
        chk("rel_rdy_b", {31'b0, rdy_b}, 32'd1);
        chk("rel_vld_a", {31'b0, rsp_vld_a}, 32'd0);

        // Byte-enable write over a cleared word, then immediate read-back.
        vld_a = 1;
        drive(1, 32'h10, 2'd0, 4'hF, 32'h0);
        tick();
        chk("a_wr_vld", {31'b0, rsp_vld_a}, 32'd1);
        chk("a_wr_rdt", rsp_rdt_a, 32'h0);
        drive(1, 32'h10, 2'd3, 4'b0101, 32'hAABBCCDD);
        tick();
        drive(0, 32'h10, 2'd0, 4'h0, 32'h0);
        tick();
        chk("a_rd_vld", {31'b0, rsp_vld_a}, 32'd1);
        chk("a_rd_rdt", rsp_rdt_a, 32'h00BB00DD);
        chk("a_rd_err", {31'b0, rsp_err_a}, 32'd0);
        vld_a = 0;
        tick();
        chk("a_idle_vld", {31'b0, rsp_vld_a}, 32'd0);
        chk("a_idle_hold", rsp_rdt_a, 32'h00BB00DD);

        // Address wrap: 0x1000 aliases word 0 for DEPTH=1024 x 32 bits.
        vld_a = 1;
        drive(1, 32'h1000, 2'd0, 4'hF, 32'hCAFEF00D);
        tick();
        drive(0, 32'h0, 2'd0, 4'h0, 32'h0);
        tick();
        chk("a_wrap_rdt", rsp_rdt_a, 32'hCAFEF00D);
        drive(0, 32'h10, 2'd0, 4'h0, 32'h0);
        tick();
        chk("a_word10_kept", rsp_rdt_a, 32'h00BB00DD);
        vld_a = 0;
        tick();

        // Log-size instance, back-to-back ops, responses exactly 3 cycles later in order.
        for (int k = 0; k < 12; k++) begin
            if (k < 9) begin
                vld_b = 1;
                drive(b_wen[k], b_adr[k], b_siz[k], 4'h0, b_wdt[k]);
            end else begin
                vld_b = 0;
                drive(0, 32'h0, 2'd0, 4'h0, 32'h0);
            end
            tick();
            if (k >= 2 && k - 2 < 9) begin
                chk($sformatf("b_vld_%0d", k - 2), {31'b0, rsp_vld_b}, 32'd1);
                chk($sformatf("b_rdt_%0d", k - 2), rsp_rdt_b, b_rdt[k-2]);
                chk($sformatf("b_err_%0d", k - 2), {31'b0, rsp_err_b}, {31'b0, b_err[k-2]});
            end else begin
                chk($sformatf("b_novld_%0d", k), {31'b0, rsp_vld_b}, 32'd0);
            end
        end
        chk("b_hold_err", {31'b0, rsp_err_b}, 32'd0);

        // Reset discards an in-flight read but keeps memory.
        vld_c = 1;
        drive(1, 32'h40, 2'd0, 4'hF, 32'h5A5A1234);
        tick();
        vld_c = 0;
        tick();
        chk("c_wr_vld", {31'b0, rsp_vld_c}, 32'd1);
        tick();
        vld_c = 1;
        drive(0, 32'h40, 2'd0, 4'h0, 32'h0);
        tick();
        vld_c = 0;
        chk("c_pre_rst_vld", {31'b0, rsp_vld_c}, 32'd0);
        rst_c = 0;
        #1;
        chk("c_rst_rdy", {31'b0, rdy_c}, 32'd0);
        chk("c_rst_rdt", rsp_rdt_c, 32'h0);
        tick();
        tick();
        rst_c = 1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("c_discard_%0d", k), {31'b0, rsp_vld_c}, 32'd0);
            tick();
        end
        vld_c = 1;
        drive(0, 32'h40, 2'd0, 4'h0, 32'h0);
        tick();
        vld_c = 0;
        chk("c_lat_vld0", {31'b0, rsp_vld_c}, 32'd0);
        tick();
        chk("c_rd_vld", {31'b0, rsp_vld_c}, 32'd1);
        chk("c_rd_rdt", rsp_rdt_c, 32'h5A5A1234);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcb_lite_sub_memory.md
TCB_LITE_SUB_MEMORY -- requirements
Module: tcb_lite_sub_memory

Interface
REQ-001 The block SHALL have parameter DELAY, default 1, fixed response delay in cycles (legal range 1..4).
REQ-002 The block SHALL have parameter WIDTH, default 32, data/address width (only 32 and 64 are legal).
REQ-003 The block SHALL have parameter MODE, default 1, bus mode (0 = logarithmic size, 1 = byte enable).
REQ-004 The block SHALL have parameter DEPTH, default 1024, memory depth in WIDTH-bit words (power of 2).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port tcb_req_vld, input, 1 bit: request valid.
REQ-008 The block SHALL have port tcb_req_rdy, output, 1 bit: request ready.
REQ-009 The block SHALL have port tcb_req_wen, input, 1 bit: write enable (1 = write, 0 = read).
REQ-010 The block SHALL have port tcb_req_adr, input, WIDTH bits: byte address.
REQ-011 The block SHALL have port tcb_req_siz, input, 2 bits: log2 transfer size in bytes (MODE=0 only).
REQ-012 The block SHALL have port tcb_req_byt, input, WIDTH/8 bits: byte enables (MODE=1 only).
REQ-013 The block SHALL have port tcb_req_wdt, input, WIDTH bits: write data.
REQ-014 The block SHALL have port tcb_rsp_vld, output, 1 bit: response valid.
REQ-015 The block SHALL have port tcb_rsp_rdt, output, WIDTH bits: read data.
REQ-016 The block SHALL have port tcb_rsp_err, output, 1 bit: response error.

Function
REQ-017 A transfer SHALL occur on every rising clk edge where tcb_req_vld and tcb_req_rdy are both 1; there is no other request handshake.
REQ-018 tcb_req_rdy SHALL be driven by a register that is 0 in reset and becomes 1 on the first clk edge after rst_n deasserts, then stays 1.
REQ-019 Word index SHALL be tcb_req_adr[log2(WIDTH/8) +: log2(DEPTH)]; higher address bits are ignored, so addresses wrap modulo DEPTH*WIDTH/8.
REQ-020 In MODE=1, a write SHALL update exactly the byte lanes with tcb_req_byt[i]=1; tcb_req_siz is ignored.
REQ-021 In MODE=0, byte enables SHALL be derived as 2^siz consecutive lanes starting at lane adr[log2(WIDTH/8)-1:0]; write data is LSB-aligned in tcb_req_wdt and shifted to that lane.
REQ-022 In MODE=0, a request with siz > log2(WIDTH/8), or with an address not aligned to 2^siz, SHALL be an error: no memory update, tcb_rsp_err=1, tcb_rsp_rdt=0.
REQ-023 In MODE=1, no request SHALL be flagged as an error.
REQ-024 A read SHALL sample the addressed word at the transfer edge; in MODE=1 it returns the full word, in MODE=0 it returns the selected bytes shifted to LSB with the upper bytes zero.
REQ-025 A write response SHALL carry tcb_rsp_rdt=0 and tcb_rsp_err=0 (unless REQ-022 applies).
REQ-026 tcb_rsp_vld, tcb_rsp_rdt and tcb_rsp_err SHALL be presented exactly DELAY cycles after the transfer edge, through a DELAY-stage pipeline, with full throughput of one transfer per cycle.
REQ-027 A read transfer on the cycle following a write to the same word SHALL return the written data.
REQ-028 In cycles without a valid response, tcb_rsp_vld SHALL be 0 and tcb_rsp_rdt/tcb_rsp_err SHALL hold their last values.
REQ-029 The response channel SHALL have no backpressure; the manager always accepts a response.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately set tcb_req_rdy=0, tcb_rsp_vld=0, tcb_rsp_rdt=0, tcb_rsp_err=0 and clear all pipeline stages.
REQ-031 Responses in flight when reset asserts SHALL be discarded and never presented.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-033 Reset release -> tcb_req_rdy=0 in the first cycle and 1 from the next edge; no tcb_rsp_vld before any transfer.
REQ-034 MODE=1, DELAY=1: write adr=0x10, byt=4'b0101, wdt=0xAABBCCDD over 0x00000000, then read 0x10 -> rdt=0x00BB00DD one cycle after the read transfer, err=0.
REQ-035 MODE=0, WIDTH=32: write siz=1, adr=0x22, wdt=0x1234, then read siz=0 at adr=0x23 -> rdt=0x00000012; read siz=2 at adr=0x22 -> err=1, rdt=0.
REQ-036 DELAY=3: back-to-back reads on 4 consecutive cycles -> 4 consecutive rsp_vld pulses starting 3 cycles after the first transfer, in request order.
REQ-037 DEPTH=1024, WIDTH=32: write adr=0x1000 with 0xCAFEF00D, read adr=0x0 -> 0xCAFEF00D (wrap-around).
REQ-038 DELAY=2: reset asserted 1 cycle after a read transfer -> no tcb_rsp_vld ever for that read; memory content written before reset still readable afterwards.
